// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch front end
package fetch_unit_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef struct packed {
        u32   raw;
        u64   pc;
        logic fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state_t;

    localparam u32 NOP_INSTR        = 32'h0000_0013;
    localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched words with flush
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_entry_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [CW-1:0] wr_q;
    logic [CW-1:0] rd_q;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign count_o = wr_q - rd_q;
    assign full    = (count_o == CW'(DEPTH));
    assign empty   = (count_o == '0);
    // a full queue still accepts a push when the head leaves in the same cycle
    assign do_push = push_i && (!full || pop_i);
    assign do_pop  = pop_i && !empty;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // pointer and storage update; flush wins over push and pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_entry_i;
                wr_q                <= wr_q + CW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with redirect and squash
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic [63:0] instr_pc,
    output logic        instr_fault
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fetch_state_t  state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   addr_q, addr_d;
    logic [CW-1:0] q_count;
    logic [CW-1:0] free;
    logic          pop;
    logic          push;
    logic          pc_aligned;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign pc_aligned  = (pc_q[1:0] == 2'b00);
    assign instr_valid = (q_count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign free        = CW'(QDEPTH) - q_count + CW'(pop);
    assign instr_raw   = head.raw;
    assign instr_pc    = head.pc;
    assign instr_fault = head.fault;

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (q_count)
    );

    // state, fetch pc and held bus address registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // bus request generation, enqueue decisions and next-state selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        push_entry = '{raw: iresp_data, pc: pc_q, fault: 1'b0};
        ireq_valid = 1'b0;
        ireq_addr  = '0;

        case (state_q)
            REQ: begin
                if (pc_aligned) begin
                    ireq_valid = 1'b1;
                    ireq_addr  = pc_q;
                end
            end
            DISCARD: begin
                ireq_valid = 1'b1;
                ireq_addr  = addr_q;
            end
            default: ;
        endcase

        // remember the address on the bus so it can be held after a redirect
        if (ireq_valid) begin
            addr_d = ireq_addr;
        end

        if (redirect_valid) begin
            pc_d = redirect_pc;
            // an unanswered request must stay on the bus until its response
            if (ireq_valid && !iresp_ok) begin
                state_d = DISCARD;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE, REQ: begin
                    if (!pc_aligned) begin
                        if (free != '0) begin
                            push       = 1'b1;
                            push_entry = '{raw: NOP_INSTR, pc: pc_q, fault: 1'b1};
                            state_d    = HALT;
                        end
                    end else if (state_q == IDLE) begin
                        if (free != '0) begin
                            state_d = REQ;
                        end
                    end else if (iresp_ok) begin
                        push    = 1'b1;
                        pc_d    = pc_q + 64'd4;
                        state_d = (free >= CW'(2)) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (iresp_ok) begin
                        state_d = REQ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
